// File: rtl/core_if_ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_if_ifu_pkg
// Purpose : Shared widths, opcode constants, the fetch-buffer entry type and
//           the RV32 J/B immediate extractors used by the fetch stage.
// Contents: c_core_pc_width, c_core_inst_width, c_opcode_jal, c_opcode_branch,
//           fetch_entry_t, imm_j(), imm_b()
// Revision: 1.0 - initial release
// ============================================================================
package core_if_ifu_pkg;

  localparam int         c_core_pc_width   = 32;
  localparam int         c_core_inst_width = 32;

  localparam logic [6:0] c_opcode_jal      = 7'b1101111;
  localparam logic [6:0] c_opcode_branch   = 7'b1100011;

  // One decoded fetch slot as handed to decode.
  typedef struct packed {
    logic [c_core_pc_width-1:0]   pc;
    logic [c_core_inst_width-1:0] inst;
    logic                         predict;
  } fetch_entry_t;

  // Sign-extended JAL offset.
  function automatic logic [c_core_pc_width-1:0] imm_j(
    input logic [c_core_inst_width-1:0] inst
  );
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // Sign-extended conditional-branch offset.
  function automatic logic [c_core_pc_width-1:0] imm_b(
    input logic [c_core_inst_width-1:0] inst
  );
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage : core_if_ifu_pkg
`default_nettype wire

// File: rtl/core_if_ifu_bpu.sv
`default_nettype none
// ============================================================================
// Module  : core_if_ifu_bpu
// Purpose : Static branch predictor. JAL is always taken; conditional
//           branches are taken when their offset is negative (backward);
//           everything else, including JALR, falls through.
// Ports   : i_inst   in  instruction being predicted
//           i_pc     in  address of that instruction
//           o_taken  out prediction
//           o_target out predicted target (valid when o_taken)
// Revision: 1.0 - initial release
// ============================================================================
module core_if_ifu_bpu
  import core_if_ifu_pkg::*;
(
  input  logic [c_core_inst_width-1:0] i_inst,
  input  logic [c_core_pc_width-1:0]   i_pc,
  output logic                         o_taken,
  output logic [c_core_pc_width-1:0]   o_target
);

  logic [6:0]                 w_opcode;
  logic                       w_is_jal;
  logic                       w_is_bwd_branch;
  logic [c_core_pc_width-1:0] w_imm;

  always_comb begin
    w_opcode        = i_inst[6:0];
    w_is_jal        = (w_opcode == c_opcode_jal);
    // Branch offset sign lives in inst[31]; backward branches look like loops.
    w_is_bwd_branch = (w_opcode == c_opcode_branch) && i_inst[31];
    w_imm           = w_is_jal ? imm_j(i_inst) : imm_b(i_inst);
    o_taken         = w_is_jal | w_is_bwd_branch;
    o_target        = i_pc + w_imm;
  end

endmodule : core_if_ifu_bpu
`default_nettype wire

// File: rtl/core_if_ifu.sv
`default_nettype none
// ============================================================================
// Module  : core_if_ifu
// Purpose : Instruction-fetch stage. Generates the fetch PC, issues in-order
//           requests to a variable-latency imem port under a credit limit,
//           predicts statically on each response, and buffers {pc, inst,
//           predict} in a small FIFO drained by decode. Flush redirects and
//           predicted-taken redirects discard the stale in-flight responses.
// Ports   : clk, rst (async, active-high)
//           o_req_valid/i_req_ready/o_req_addr    imem request
//           i_rsp_valid/i_rsp_inst                imem response (in order)
//           i_pipe_flush_req/i_flush_pc           redirect from execute
//           o_valid/i_ready                       decode handshake
//           o_pc/o_inst/o_branch_predict          FIFO head
// Revision: 1.0 - initial release
// ============================================================================
module core_if_ifu
  import core_if_ifu_pkg::*;
#(
  parameter logic [c_core_pc_width-1:0] PC_RESET   = 32'h8000_0000,
  parameter int                         FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         o_req_valid,
  input  logic                         i_req_ready,
  output logic [c_core_pc_width-1:0]   o_req_addr,
  input  logic                         i_rsp_valid,
  input  logic [c_core_inst_width-1:0] i_rsp_inst,
  input  logic                         i_pipe_flush_req,
  input  logic [c_core_pc_width-1:0]   i_flush_pc,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [c_core_pc_width-1:0]   o_pc,
  output logic [c_core_inst_width-1:0] o_inst,
  output logic                         o_branch_predict
);

  localparam int                         c_cnt_w        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_cnt_w:0]           c_credit_limit = (c_cnt_w + 1)'(FIFO_DEPTH);
  localparam logic [c_core_pc_width-1:0] c_pc_step      = 4;

  // Control state
  logic                       r_started;
  logic [c_core_pc_width-1:0] r_pc;
  logic [c_cnt_w-1:0]         r_outstanding;
  logic [c_cnt_w-1:0]         r_drop_cnt;

  // PCs of live (not-to-be-dropped) requests, oldest at index 0.
  logic [c_core_pc_width-1:0] r_pcq [FIFO_DEPTH];
  logic [c_cnt_w-1:0]         r_pcq_cnt;

  // Output buffer, head at index 0.
  fetch_entry_t               r_fifo [FIFO_DEPTH];
  logic [c_cnt_w-1:0]         r_fifo_cnt;

  logic                       w_bpu_taken;
  logic [c_core_pc_width-1:0] w_bpu_target;
  logic                       w_dropping;
  logic                       w_rsp_accept;
  logic                       w_redirect;
  logic                       w_credit_ok;
  logic                       w_req_hs;
  logic                       w_pop;
  logic [c_cnt_w-1:0]         w_out_after_rsp;
  logic [c_cnt_w-1:0]         w_fifo_wr_idx;
  logic [c_cnt_w-1:0]         w_pcq_wr_idx;
  fetch_entry_t               w_push_entry;

  // The response always belongs to the oldest live request.
  core_if_ifu_bpu u_bpu (
    .i_inst   (i_rsp_inst),
    .i_pc     (r_pcq[0]),
    .o_taken  (w_bpu_taken),
    .o_target (w_bpu_target)
  );

  always_comb begin
    w_dropping      = (r_drop_cnt != '0);
    w_rsp_accept    = i_rsp_valid & ~i_pipe_flush_req & ~w_dropping;
    w_redirect      = w_rsp_accept & w_bpu_taken;
    // Requests in flight plus buffered entries never exceed the FIFO depth,
    // so every response is guaranteed a slot.
    w_credit_ok     = ({1'b0, r_outstanding} + {1'b0, r_fifo_cnt}) < c_credit_limit;
    o_req_valid     = r_started & ~i_pipe_flush_req & ~w_redirect & w_credit_ok;
    o_req_addr      = r_pc;
    w_req_hs        = o_req_valid & i_req_ready;
    w_out_after_rsp = r_outstanding - c_cnt_w'(i_rsp_valid);

    o_valid          = (r_fifo_cnt != '0) & ~i_pipe_flush_req;
    w_pop            = o_valid & i_ready;
    o_pc             = r_fifo[0].pc;
    o_inst           = r_fifo[0].inst;
    o_branch_predict = r_fifo[0].predict;

    w_fifo_wr_idx        = r_fifo_cnt - c_cnt_w'(w_pop);
    w_pcq_wr_idx         = r_pcq_cnt - c_cnt_w'(w_rsp_accept);
    w_push_entry.pc      = r_pcq[0];
    w_push_entry.inst    = i_rsp_inst;
    w_push_entry.predict = w_bpu_taken;
  end

  // PC, credit and drop bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_started     <= 1'b0;
      r_pc          <= PC_RESET;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_started     <= 1'b1;
      r_outstanding <= r_outstanding + c_cnt_w'(w_req_hs) - c_cnt_w'(i_rsp_valid);
      if (i_pipe_flush_req) begin
        r_pc       <= i_flush_pc;
        r_drop_cnt <= w_out_after_rsp;
      end else if (w_redirect) begin
        // Everything still in flight was fetched down the fall-through path.
        r_pc       <= w_bpu_target;
        r_drop_cnt <= w_out_after_rsp;
      end else begin
        if (w_req_hs) begin
          r_pc <= r_pc + c_pc_step;
        end
        if (i_rsp_valid && w_dropping) begin
          r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
        end
      end
    end
  end

  // PC queue: push on request handshake, pop on accepted response. Dropped
  // responses never had a live entry, so a flush/redirect simply empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcq_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_pcq[i] <= '0;
      end
    end else if (i_pipe_flush_req || w_redirect) begin
      r_pcq_cnt <= '0;
    end else begin
      r_pcq_cnt <= r_pcq_cnt + c_cnt_w'(w_req_hs) - c_cnt_w'(w_rsp_accept);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_req_hs && (c_cnt_w'(i) == w_pcq_wr_idx)) begin
          r_pcq[i] <= r_pc;
        end else if (w_rsp_accept && (i < FIFO_DEPTH - 1)) begin
          r_pcq[i] <= r_pcq[i+1];
        end
      end
    end
  end

  // Output FIFO: shift on pop, write at the slot that is free after the pop,
  // so push and pop in the same cycle work at full occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
    end else if (i_pipe_flush_req) begin
      r_fifo_cnt <= '0;
    end else begin
      r_fifo_cnt <= r_fifo_cnt + c_cnt_w'(w_rsp_accept) - c_cnt_w'(w_pop);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_rsp_accept && (c_cnt_w'(i) == w_fifo_wr_idx)) begin
          r_fifo[i] <= w_push_entry;
        end else if (w_pop && (i < FIFO_DEPTH - 1)) begin
          r_fifo[i] <= r_fifo[i+1];
        end
      end
    end
  end

endmodule : core_if_ifu
`default_nettype wire

// File: tb/tb_core_if_ifu.sv
`default_nettype none
// ============================================================================
// Module  : tb_core_if_ifu
// Purpose : Self-checking bench for core_if_ifu. An imem model answers
//           requests in order after a chosen latency; a queue-level reference
//           model (in-flight list with stale tags, delivery queue) predicts
//           every output each cycle. Directed phases pin literal addresses.
// Revision: 1.0 - initial release
// ============================================================================
module tb_core_if_ifu;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  localparam int K_NOP = 0, K_JAL = 1, K_BR = 2, K_JALR = 3, K_ALU = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        o_req_valid;
  logic        i_req_ready = 1'b0;
  logic [31:0] o_req_addr;
  logic        i_rsp_valid = 1'b0;
  logic [31:0] i_rsp_inst = '0;
  logic        i_pipe_flush_req = 1'b0;
  logic [31:0] i_flush_pc = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic        o_branch_predict;

  always #5 clk = ~clk;

  core_if_ifu #(.PC_RESET(RST_PC), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .o_req_valid      (o_req_valid),
    .i_req_ready      (i_req_ready),
    .o_req_addr       (o_req_addr),
    .i_rsp_valid      (i_rsp_valid),
    .i_rsp_inst       (i_rsp_inst),
    .i_pipe_flush_req (i_pipe_flush_req),
    .i_flush_pc       (i_flush_pc),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_pc             (o_pc),
    .o_inst           (o_inst),
    .o_branch_predict (o_branch_predict)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int prog_mode = 0;
  int last_due  = 0;

  typedef struct { logic [31:0] pc; logic stale; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic pred; } ent_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  fl_t         m_fl[$];     // requests in flight, oldest first
  ent_t        m_q[$];      // instructions waiting for decode
  pend_t       pend[$];     // imem model's pending responses
  logic [31:0] m_pc;
  logic        m_started;
  logic [31:0] dlv_pc[$];
  logic        dlv_pred[$];

  // ---------------- program image ----------------
  function automatic void gen(input logic [31:0] a, output int kind, output int imm);
    logic [31:0] h;
    kind = K_NOP;
    imm  = 0;
    if (prog_mode == 0) begin
      case (a)
        32'h8000_0008: begin kind = K_JAL; imm = 256; end
        32'h8000_0108: begin kind = K_BR;  imm = 8;   end
        32'h8000_010C: kind = K_JALR;
        32'h8000_0110: begin kind = K_BR;  imm = -8;  end
        default: ;
      endcase
    end else begin
      h = (a >> 2) * 32'h9E37_79B1;
      h = h ^ (h >> 15);
      imm = (int'(h[13:8]) - 32) * 4;
      case (h[19:16])
        4'd10, 4'd11:        kind = K_JAL;
        4'd12, 4'd13, 4'd15: kind = K_BR;
        4'd14:               kind = K_JALR;
        4'd9, 4'd8:          begin kind = K_ALU; imm = int'(h); end
        default:             kind = K_NOP;
      endcase
    end
  endfunction

  function automatic logic [31:0] enc(input int kind, input int imm);
    logic [31:0] i;
    i = imm;
    case (kind)
      K_JAL:   enc = {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
      K_BR:    enc = {i[12], i[10:5], 5'd2, 5'd1, 3'b000, i[4:1], i[11], 7'b1100011};
      K_JALR:  enc = {12'd0, 5'd1, 3'b000, 5'd0, 7'b1100111};
      K_ALU:   enc = {i[31:7], 7'b0110011};
      default: enc = NOP;
    endcase
  endfunction

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    int k, m;
    gen(a, k, m);
    return enc(k, m);
  endfunction

  // Prediction rule: JAL taken, backward conditional branch taken.
  function automatic void predict(input logic [31:0] pc, output logic tk, output logic [31:0] tgt);
    int k, m;
    gen(pc, k, m);
    tk  = (k == K_JAL) || ((k == K_BR) && (m < 0));
    tgt = pc + m;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = RST_PC;
    m_fl.delete();
    m_q.delete();
    pend.delete();
    m_started = 1'b0;
    last_due  = 0;
  endtask

  // One clock cycle: called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic flush, input logic [31:0] fpc, input logic rdy,
                      input logic qrdy, input int lat);
    logic        rsp, acc, tk, redir, ev, er, hs;
    logic [31:0] rinst, tgt;
    fl_t         hd;
    ent_t        e;
    fl_t         nf;
    pend_t       np;
    rsp = 1'b0; rinst = '0; hd.pc = '0; hd.stale = 1'b1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rsp   = 1'b1;
      rinst = inst_at(pend[0].addr);
      void'(pend.pop_front());
      if (m_fl.size() > 0) hd = m_fl[0];
    end
    i_rsp_valid      = rsp;
    i_rsp_inst       = rinst;
    i_pipe_flush_req = flush;
    i_flush_pc       = fpc;
    i_ready          = rdy;
    i_req_ready      = qrdy;

    acc = rsp && !flush && !hd.stale;
    predict(hd.pc, tk, tgt);
    redir = acc && tk;
    ev = (m_q.size() > 0) && !flush;
    er = m_started && !flush && !redir && ((m_fl.size() + m_q.size()) < DEPTH);

    #1;
    chk("o_valid", {31'b0, o_valid}, {31'b0, ev});
    chk("o_req_valid", {31'b0, o_req_valid}, {31'b0, er});
    if (ev) begin
      chk("o_pc", o_pc, m_q[0].pc);
      chk("o_inst", o_inst, m_q[0].inst);
      chk("o_branch_predict", {31'b0, o_branch_predict}, {31'b0, m_q[0].pred});
    end
    if (er) chk("o_req_addr", o_req_addr, m_pc);

    hs = er && qrdy;
    if (ev && rdy) begin
      dlv_pc.push_back(m_q[0].pc);
      dlv_pred.push_back(m_q[0].pred);
      void'(m_q.pop_front());
    end
    if (rsp && m_fl.size() > 0) void'(m_fl.pop_front());
    if (acc) begin
      e.pc = hd.pc; e.inst = rinst; e.pred = tk;
      m_q.push_back(e);
    end
    if (hs) begin
      nf.pc = m_pc; nf.stale = 1'b0;
      m_fl.push_back(nf);
      if (cyc + lat > last_due) last_due = cyc + lat;
      np.addr = m_pc; np.due = last_due;
      pend.push_back(np);
      m_pc = m_pc + 32'd4;
    end
    if (flush) begin
      m_pc = fpc;
      m_q.delete();
      foreach (m_fl[k]) m_fl[k].stale = 1'b1;
    end else if (redir) begin
      m_pc = tgt;
      foreach (m_fl[k]) m_fl[k].stale = 1'b1;
    end
    m_started = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Reset asserted between clock edges; outputs must drop without an edge.
  task automatic mid_reset();
    rst = 1'b1;
    #1;
    chk("midrst_o_valid", {31'b0, o_valid}, 32'd0);
    chk("midrst_o_req_valid", {31'b0, o_req_valid}, 32'd0);
    i_rsp_valid = 1'b0; i_pipe_flush_req = 1'b0; i_req_ready = 1'b0; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    cyc += 2;
    #1;
    m_reset();
    rst = 1'b0;
  endtask

  logic [31:0] exp_pc   [7] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_0108,
                                32'h8000_010C, 32'h8000_0110, 32'h8000_0108};
  logic        exp_pred [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int n0;
    m_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_o_req_valid", {31'b0, o_req_valid}, 32'd0);
    chk("rst_o_pc", o_pc, 32'd0);
    chk("rst_o_inst", o_inst, 32'd0);
    chk("rst_o_branch_predict", {31'b0, o_branch_predict}, 32'd0);
    rst = 1'b0;

    // Directed: L=1, decode always ready, JAL and backward/forward branches.
    prog_mode = 0;
    for (int n = 0; n < 40; n++) step(1'b0, '0, 1'b1, 1'b1, 1);
    if (dlv_pc.size() < 7) begin
      n_tests++; n_fail++;
      $display("FAIL dlv_count got=%0d exp>=7", dlv_pc.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("dlv_pc%0d", i), dlv_pc[i], exp_pc[i]);
        chk($sformatf("dlv_pred%0d", i), {31'b0, dlv_pred[i]}, {31'b0, exp_pred[i]});
      end
    end

    // Decode stalled for 5 cycles, then released.
    for (int n = 0; n < 5; n++)  step(1'b0, '0, 1'b0, 1'b1, 1);
    for (int n = 0; n < 10; n++) step(1'b0, '0, 1'b1, 1'b1, 2);

    // Flush with long-latency responses in flight.
    for (int n = 0; n < 4; n++) step(1'b0, '0, 1'b0, 1'b1, 3);
    step(1'b1, 32'h8000_0400, 1'b1, 1'b1, 3);
    n0 = dlv_pc.size();
    for (int n = 0; n < 20; n++) step(1'b0, '0, 1'b1, 1'b1, 2);
    if (dlv_pc.size() <= n0) begin
      n_tests++; n_fail++;
      $display("FAIL flush_resume got=none exp=80000400");
    end else begin
      chk("flush_first_pc", dlv_pc[n0], 32'h8000_0400);
    end

    // Reset in the middle of traffic with a nonempty buffer.
    for (int n = 0; n < 3; n++) step(1'b0, '0, 1'b0, 1'b1, 1);
    mid_reset();

    // Randomized phase.
    prog_mode = 1;
    for (int n = 0; n < 3000; n++) begin
      logic        fl, tk;
      logic [31:0] fpc, tg;
      fl = ($urandom_range(0, 99) < 4);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        predict(pend[0].addr, tk, tg);
        if (tk && ($urandom_range(0, 3) == 0)) fl = 1'b1;
      end
      fpc = 32'h8000_0000 + (32'($urandom_range(0, 1023)) << 2);
      if (n == 1500) mid_reset();
      step(fl, fpc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(1, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule : tb_core_if_ifu
`default_nettype wire
